seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_scan_driver.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display drivers: segment lookup,
// segment bit positions and a helper for counter/index widths.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Segment bit positions inside the {a,b,c,d,e,f,g} word.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-high patterns; entry 15 is leftmost.
  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high 7-segment pattern, with a blank
// input that forces every segment off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic             blank,
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_LUT[nib];
    if (blank) begin
      seg = '0;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: refresh divider, digit scan,
// double-buffered value load, leading-zero blanking and anode guard time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int IW = idx_width(DIGITS);
  localparam int CW = idx_width(REFRESH_DIV);
  localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    stg_val_q, stg_val_d, dsp_val_q, dsp_val_d;
  logic [DIGITS-1:0]      stg_dp_q, stg_dp_d, dsp_dp_q, dsp_dp_d;
  logic                   stg_lz_q, stg_lz_d, dsp_lz_q, dsp_lz_d;
  logic                   pending_q, pending_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   fs_q, fs_d;

  logic                   cnt_last, idx_last, wrap;
  logic [DIGITS-1:0]      blank;
  logic [DIGITS:1]        zero_chain;
  logic [SEG_W-1:0]       dig_seg [DIGITS];

  assign cnt_last = (cnt_q == CW'(REFRESH_DIV - 1));
  assign idx_last = (idx_q == IW'(DIGITS - 1));
  assign wrap     = cnt_last && idx_last;

  // zero_chain[k] is set when lz is latched and digits k..DIGITS-1 are all zero.
  assign zero_chain[DIGITS] = dsp_lz_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign zero_chain[gi] = zero_chain[gi+1] & (dsp_val_q[4*gi +: 4] == 4'h0);
      assign blank[gi]      = zero_chain[gi];
    end

    seg7_decode u_decode (
      .blank (blank[gi]),
      .nib   (dsp_val_q[4*gi +: 4]),
      .seg   (dig_seg[gi])
    );
  end

  always_comb begin
    cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    stg_val_d = stg_val_q;
    stg_dp_d  = stg_dp_q;
    stg_lz_d  = stg_lz_q;
    dsp_val_d = dsp_val_q;
    dsp_dp_d  = dsp_dp_q;
    dsp_lz_d  = dsp_lz_q;
    pending_d = pending_q;

    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end

    // Transfer uses the old staging contents, so a load on this same cycle
    // lands in staging and waits for the following frame.
    if (wrap) begin
      dsp_val_d = stg_val_q;
      dsp_dp_d  = stg_dp_q;
      dsp_lz_d  = stg_lz_q;
      pending_d = 1'b0;
    end

    if (load) begin
      stg_val_d = value;
      stg_dp_d  = dp_in;
      stg_lz_d  = lz_en;
      pending_d = 1'b1;
    end
  end

  // Output stage: pattern follows the new digit immediately, anodes wait out the guard.
  always_comb begin
    seg_d = dig_seg[idx_q] ^ SEG_OFF;
    dp_d  = dsp_dp_q[idx_q] ^ SEG_OFF[0];
    an_d  = AN_OFF;
    if (cnt_q >= CW'(GUARD)) begin
      an_d = (DIGITS'(1) << idx_q) ^ AN_OFF;
    end
    fs_d  = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      stg_val_q <= '0;
      stg_dp_q  <= '0;
      stg_lz_q  <= 1'b0;
      dsp_val_q <= '0;
      dsp_dp_q  <= '0;
      dsp_lz_q  <= 1'b0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= SEG_OFF[0];
      an_q      <= AN_OFF;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stg_val_q <= stg_val_d;
      stg_dp_q  <= stg_dp_d;
      stg_lz_q  <= stg_lz_d;
      dsp_val_q <= dsp_val_d;
      dsp_dp_q  <= dsp_dp_d;
      dsp_lz_q  <= dsp_lz_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fs_q      <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a timeline model predicts every
// output cycle from the load history; a negedge monitor compares.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
  localparam int FR = D * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS         (D),
    .REFRESH_DIV    (RD),
    .GUARD          (G),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp_in       (dp_in),
    .load        (load),
    .lz_en       (lz_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  typedef struct {
    int          e;
    logic [15:0] v;
    logic [3:0]  d;
    logic        l;
  } ld_t;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
    logic       pend;
  } exp_t;

  ld_t  ld_log[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;

  logic [6:0] pat [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("seg",  32'(seg),         32'(mon_e.seg));
      chk("dp",   32'(dp),          32'(mon_e.dp));
      chk("an",   32'(an),          32'(mon_e.an));
      chk("fs",   32'(frame_start), 32'(mon_e.fs));
      chk("pend", 32'(pending),     32'(mon_e.pend));
      $display("cyc n=%0d seg=%b dp=%b an=%b fs=%b pend=%b", n, seg, dp, an, frame_start, pending);
    end
  end

  // One clock of stimulus; n counts edges since reset was released.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic l);
    exp_t        e;
    ld_t         x;
    int          frame_edge, w, last, idx, cnt;
    logic [15:0] dv;
    logic [3:0]  ddp;
    logic        dlz;
    logic [3:0]  nib;
    logic        blank;
    rst   = r;
    load  = ld;
    value = v;
    dp_in = d;
    lz_en = l;
    if (r) begin
      ld_log.delete();
      n = 0;
      e = '{7'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    end else begin
      if (ld) begin
        x.e = n; x.v = v; x.d = d; x.l = l;
        ld_log.push_back(x);
      end
      // A frame shows the last load made at least two edges before it starts.
      frame_edge = (n / FR) * FR;
      dv = 16'h0; ddp = 4'h0; dlz = 1'b0;
      foreach (ld_log[i]) begin
        if (ld_log[i].e <= frame_edge - 2) begin
          dv = ld_log[i].v; ddp = ld_log[i].d; dlz = ld_log[i].l;
        end
      end
      cnt   = n % RD;
      idx   = (n / RD) % D;
      nib   = dv[4*idx +: 4];
      blank = dlz && (idx > 0) && ((dv >> (4*idx)) == 16'h0);
      e.seg = blank ? 7'd0 : pat[nib];
      e.dp  = ddp[idx];
      e.an  = (cnt >= G) ? 4'(1 << idx) : 4'd0;
      e.fs  = (n % FR) == 0;
      w     = (n >= FR - 1) ? n - ((n - (FR - 1)) % FR) : -1;
      last  = (ld_log.size() > 0) ? ld_log[ld_log.size()-1].e : -1;
      e.pend = (last >= 0) && (last >= w);
      n++;
    end
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FR && (n % FR) != p; i++) begin
      run(1);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;
    @(negedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    run(20);

    step(1'b0, 1'b1, 16'h1234, 4'b0010, 1'b0);
    run(40);

    for (int h = 0; h < 16; h++) begin
      wait_phase(0);
      step(1'b0, 1'b1, 16'(h), 4'b0000, 1'b0);
    end
    run(32);

    step(1'b0, 1'b1, 16'h0050, 4'b1100, 1'b1);
    run(32);
    step(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
    run(32);

    wait_phase(4);
    step(1'b0, 1'b1, 16'hAAAA, 4'b0000, 1'b0);
    run(1);
    step(1'b0, 1'b1, 16'hBBBB, 4'b0000, 1'b0);
    run(40);

    wait_phase(15);
    step(1'b0, 1'b1, 16'hC0DE, 4'b0101, 1'b0);
    run(33);

    wait_phase(4);
    step(1'b0, 1'b1, 16'h9876, 4'b1111, 1'b0);
    wait_phase(9);
    step(1'b1, 1'b1, 16'h5555, 4'b1111, 1'b1);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
